// File: rtl/mbist_march_gen.sv
// MBIST march sequence generator for a single-port RAM: Checkerboard, MATS+ and March C-
// run in fixed order, one read or write per cycle, with expected data and compare strobe.
module mbist_march_gen #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 36
) (
  input  logic              as_clk,
  input  logic              as_rst,
  input  logic              as_start,
  input  logic [2:0]        as_algsel,
  input  logic              as_pause,
  output logic [ADDR_W-1:0] as_addr,
  output logic [DATA_W-1:0] as_wdata,
  output logic              as_we,
  output logic              as_re,
  output logic [DATA_W-1:0] as_exp,
  output logic              as_check_ce,
  output logic [1:0]        as_alg_id,
  output logic [2:0]        as_elem,
  output logic              as_busy,
  output logic              as_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Data kinds used by the element table
  localparam logic [1:0] DZero = 2'd0;
  localparam logic [1:0] DOne  = 2'd1;
  localparam logic [1:0] DPat  = 2'd2;
  localparam logic [1:0] DInv  = 2'd3;

  localparam logic [ADDR_W-1:0]   LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]   AddrOne  = ADDR_W'(1);
  localparam logic [2*DATA_W-1:0] CbWide   = {DATA_W{2'b10}};
  localparam logic [DATA_W-1:0]   Cb       = CbWide[DATA_W-1:0];

  typedef struct packed {
    logic       last;  // final element of the algorithm
    logic       down;
    logic       two;   // element has two ops per address
    logic       rd0;
    logic [1:0] d0;
    logic       rd1;
    logic [1:0] d1;
  } elem_t;

  function automatic elem_t elem_desc(input logic [1:0] alg, input logic [2:0] elem);
    elem_t d;
    case ({alg, elem})
      {2'd0, 3'd0}: d = '{1'b0, 1'b0, 1'b0, 1'b0, DPat,  1'b0, DZero};
      {2'd0, 3'd1}: d = '{1'b0, 1'b0, 1'b0, 1'b1, DPat,  1'b0, DZero};
      {2'd0, 3'd2}: d = '{1'b0, 1'b0, 1'b0, 1'b0, DInv,  1'b0, DZero};
      {2'd0, 3'd3}: d = '{1'b1, 1'b0, 1'b0, 1'b1, DInv,  1'b0, DZero};
      {2'd1, 3'd0}: d = '{1'b0, 1'b0, 1'b0, 1'b0, DZero, 1'b0, DZero};
      {2'd1, 3'd1}: d = '{1'b0, 1'b0, 1'b1, 1'b1, DZero, 1'b0, DOne};
      {2'd1, 3'd2}: d = '{1'b1, 1'b1, 1'b1, 1'b1, DOne,  1'b0, DZero};
      {2'd2, 3'd0}: d = '{1'b0, 1'b0, 1'b0, 1'b0, DZero, 1'b0, DZero};
      {2'd2, 3'd1}: d = '{1'b0, 1'b0, 1'b1, 1'b1, DZero, 1'b0, DOne};
      {2'd2, 3'd2}: d = '{1'b0, 1'b0, 1'b1, 1'b1, DOne,  1'b0, DZero};
      {2'd2, 3'd3}: d = '{1'b0, 1'b1, 1'b1, 1'b1, DZero, 1'b0, DOne};
      {2'd2, 3'd4}: d = '{1'b0, 1'b1, 1'b1, 1'b1, DOne,  1'b0, DZero};
      {2'd2, 3'd5}: d = '{1'b1, 1'b0, 1'b0, 1'b1, DZero, 1'b0, DZero};
      default:      d = '{1'b1, 1'b0, 1'b0, 1'b0, DZero, 1'b0, DZero};
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] pat_data(input logic [1:0] kind,
                                                  input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] p;
    p = addr[0] ? ~Cb : Cb;
    case (kind)
      DZero:   return '0;
      DOne:    return '1;
      DPat:    return p;
      default: return ~p;
    endcase
  endfunction

  state_e            state_q;
  logic [2:1]        sel_q;
  logic [1:0]        alg_q, alg_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;
  logic              fin_q, fin_d;
  logic [DATA_W-1:0] exp_pend_q;

  elem_t             cur, nxt;
  logic              cur_rd, last_addr;
  logic [DATA_W-1:0] cur_data;
  logic              first_valid;
  logic [1:0]        first_alg;

  always_comb begin
    first_valid = 1'b1;
    first_alg   = 2'd0;
    if (as_algsel[0])      first_alg = 2'd0;
    else if (as_algsel[1]) first_alg = 2'd1;
    else if (as_algsel[2]) first_alg = 2'd2;
    else                   first_valid = 1'b0;
  end

  // Step to the next op: op within address, then address, element, selected algorithm
  always_comb begin
    cur       = elem_desc(alg_q, elem_q);
    nxt       = elem_desc(alg_q, elem_q + 3'd1);
    cur_rd    = op_q ? cur.rd1 : cur.rd0;
    cur_data  = pat_data(op_q ? cur.d1 : cur.d0, addr_q);
    last_addr = cur.down ? (addr_q == '0) : (addr_q == LastAddr);
    alg_d     = alg_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    op_d      = 1'b0;
    fin_d     = 1'b0;
    if (cur.two && !op_q) begin
      op_d = 1'b1;
    end else if (!last_addr) begin
      addr_d = cur.down ? addr_q - AddrOne : addr_q + AddrOne;
    end else if (!cur.last) begin
      elem_d = elem_q + 3'd1;
      addr_d = nxt.down ? LastAddr : '0;
    end else if (alg_q == 2'd0 && sel_q[1]) begin
      alg_d  = 2'd1;
      elem_d = '0;
      addr_d = '0;
    end else if (alg_q != 2'd2 && sel_q[2]) begin
      alg_d  = 2'd2;
      elem_d = '0;
      addr_d = '0;
    end else begin
      fin_d = 1'b1;
    end
  end

  always_ff @(posedge as_clk or posedge as_rst) begin
    if (as_rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      alg_q       <= '0;
      elem_q      <= '0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      fin_q       <= 1'b0;
      exp_pend_q  <= '0;
      as_addr     <= '0;
      as_wdata    <= '0;
      as_we       <= 1'b0;
      as_re       <= 1'b0;
      as_exp      <= '0;
      as_check_ce <= 1'b0;
      as_alg_id   <= '0;
      as_elem     <= '0;
      as_busy     <= 1'b0;
      as_done     <= 1'b0;
    end else begin
      // The strobe trails the read by one cycle, whatever happens to sequencing meanwhile
      as_check_ce <= as_re;
      if (as_re) as_exp <= exp_pend_q;
      case (state_q)
        StIdle, StDone: begin
          if (as_start) begin
            sel_q   <= as_algsel[2:1];
            as_busy <= 1'b1;
            as_done <= 1'b0;
            alg_q   <= first_alg;
            elem_q  <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            fin_q   <= 1'b0;
            state_q <= first_valid ? StRun : StDrain;
          end
        end
        StRun: begin
          if (fin_q) begin
            as_we   <= 1'b0;
            as_re   <= 1'b0;
            state_q <= StDrain;
          end else if (as_pause) begin
            as_we <= 1'b0;
            as_re <= 1'b0;
          end else begin
            as_addr    <= addr_q;
            as_we      <= !cur_rd;
            as_re      <= cur_rd;
            if (!cur_rd) as_wdata <= cur_data;
            exp_pend_q <= cur_data;
            as_alg_id  <= alg_q;
            as_elem    <= elem_q;
            alg_q      <= alg_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            fin_q      <= fin_d;
          end
        end
        StDrain: begin
          as_we   <= 1'b0;
          as_re   <= 1'b0;
          as_busy <= 1'b0;
          as_done <= 1'b1;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_gen.sv
// Randomized bench for mbist_march_gen: ops are predicted from the march notation of each
// algorithm and replayed cycle by cycle with random pause and ignored start pulses.
module tb_mbist_march_gen;

  localparam int AW = 3;
  localparam int D  = 5;
  localparam int DW = 4;

  logic          clk, rst, start, pause;
  logic [2:0]    algsel;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, expd;
  logic          we, re, ce, busy, done;
  logic [1:0]    alg_id;
  logic [2:0]    elem;

  mbist_march_gen #(.ADDR_W(AW), .DEPTH(D), .DATA_W(DW)) dut (
    .as_clk(clk), .as_rst(rst), .as_start(start), .as_algsel(algsel), .as_pause(pause),
    .as_addr(addr), .as_wdata(wdata), .as_we(we), .as_re(re), .as_exp(expd),
    .as_check_ce(ce), .as_alg_id(alg_id), .as_elem(elem), .as_busy(busy), .as_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    int            addr;
    logic [DW-1:0] data;
    int            alg;
    int            elem;
  } op_t;

  op_t           q[$];
  string         tab[3][6];
  int            nel[3];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            hold_addr = 0;
  logic [DW-1:0] hold_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] cb;
    for (int i = 0; i < DW; i++) cb[i] = (i % 2 == 1);
    return (a % 2 == 1) ? ~cb : cb;
  endfunction

  function automatic logic [DW-1:0] val(input byte c, input int a);
    if (c == "0") return '0;
    if (c == "1") return '1;
    if (c == "P") return pat(a);
    return ~pat(a);
  endfunction

  // Expand march notation ("Ur0w1" = up, read 0 then write 1) into a flat op list
  task automatic build(input logic [2:0] sel);
    q.delete();
    for (int a = 0; a < 3; a++) begin
      if (!sel[a]) continue;
      for (int e = 0; e < nel[a]; e++) begin
        string s;
        s = tab[a][e];
        for (int i = 0; i < D; i++) begin
          int ad;
          ad = (s[0] == "D") ? D - 1 - i : i;
          for (int j = 1; j + 1 < s.len(); j += 2) begin
            op_t o;
            o.we   = (s[j] == "w");
            o.addr = ad;
            o.data = val(s[j+1], ad);
            o.alg  = a;
            o.elem = e;
            q.push_back(o);
          end
        end
      end
    end
  endtask

  // Called and returns at a negedge
  task automatic run_seq(input logic [2:0] sel, input int pct);
    int            n, idx, cyc;
    bit            p, pre;
    logic [DW-1:0] pdata;
    op_t           o;
    build(sel);
    n = q.size();
    chk("run_len", 64'(n), 64'(4*D*sel[0] + 5*D*sel[1] + 10*D*sel[2]));
    start  = 1'b1;
    algsel = sel;
    pause  = 1'($urandom_range(0, 1));
    @(negedge clk);
    start  = 1'b0;
    algsel = 3'($urandom);
    chk("start_flags", {busy, done, we, re, ce}, 5'b10000);
    if (n == 0) begin
      pause = 1'b0;
      @(negedge clk);
      chk("empty_done", {busy, done, we, re, ce}, 5'b01000);
      return;
    end
    idx   = 0;
    cyc   = 0;
    pre   = 1'b0;
    pdata = '0;
    while (idx < n) begin
      p = (cyc < 4 * n) && ($urandom_range(0, 99) < pct);
      pause  = p;
      start  = ($urandom_range(0, 7) == 0);
      algsel = 3'($urandom);
      @(negedge clk);
      cyc++;
      if (pre) chk("exp", 64'(expd), 64'(pdata));
      if (p) begin
        chk("pause_flags", {busy, done, we, re, ce}, {4'b1000, pre});
        chk("pause_addr", 64'(addr), 64'(hold_addr));
        chk("pause_wdata", 64'(wdata), 64'(hold_wdata));
        pre = 1'b0;
      end else begin
        o = q[idx];
        idx++;
        chk("op_flags", {busy, done, we, re, ce}, {2'b10, o.we, !o.we, pre});
        chk("op_addr", 64'(addr), 64'(o.addr));
        chk("op_alg", 64'(alg_id), 64'(o.alg));
        chk("op_elem", 64'(elem), 64'(o.elem));
        hold_addr = o.addr;
        if (o.we) begin
          chk("op_wdata", 64'(wdata), 64'(o.data));
          hold_wdata = o.data;
        end
        pre   = !o.we;
        pdata = o.data;
      end
    end
    pause = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("drain_flags", {busy, done, we, re, ce}, {4'b1000, pre});
    if (pre) chk("drain_exp", 64'(expd), 64'(pdata));
    @(negedge clk);
    chk("done_flags", {busy, done, we, re, ce}, 5'b01000);
  endtask

  initial begin
    tab[0] = '{"UwP", "UrP", "UwN", "UrN", "", ""};
    tab[1] = '{"Uw0", "Ur0w1", "Dr1w0", "", "", ""};
    tab[2] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Ur0"};
    nel    = '{4, 3, 6};
    rst    = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    algsel = '0;
    #1;
    chk("reset_outs", {addr, wdata, we, re, expd, ce, alg_id, elem, busy, done}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {addr, wdata, we, re, expd, ce, alg_id, elem, busy, done}, '0);

    run_seq(3'b010, 0);
    run_seq(3'b000, 0);
    run_seq(3'b100, 0);
    run_seq(3'b001, 0);
    run_seq(3'b111, 25);
    for (int r = 0; r < 10; r++) run_seq(3'($urandom), 30);

    // Abort March C- partway into element 2 with an asynchronous reset
    start  = 1'b1;
    algsel = 3'b100;
    pause  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * D + D + 3) @(negedge clk);
    chk("abort_elem", 64'(elem), 64'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {addr, wdata, we, re, expd, ce, alg_id, elem, busy, done}, '0);
    @(negedge clk);
    rst        = 1'b0;
    hold_addr  = 0;
    hold_wdata = '0;
    @(negedge clk);
    run_seq(3'b100, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
